wb_control: RTL and testbench

WB_CONTROL -- requirements
Module: wb_control

---
 rtl/wb_control_pkg.sv | 71 +++++++
 rtl/wb_scoreboard.sv | 57 +++++
 rtl/wb_control.sv | 122 ++++++++++++
 tb/tb_wb_control.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_control_pkg.sv
// Shared processor definitions: opcodes, register addressing, write-back mux encodings
// and instruction decode helpers used by the write-back control slice.
package wb_control_pkg;

    localparam int unsigned IrW      = 8;
    localparam int unsigned RegAddrW = 2;
    localparam int unsigned NumRegs  = 4;

    localparam logic [3:0] OpLoad  = 4'b0000;
    localparam logic [3:0] OpStop  = 4'b0001;
    localparam logic [3:0] OpStore = 4'b0010;
    localparam logic [3:0] OpAdd   = 4'b0100;
    localparam logic [3:0] OpBz    = 4'b0101;
    localparam logic [3:0] OpSub   = 4'b0110;
    localparam logic [3:0] OpNand  = 4'b1000;
    localparam logic [3:0] OpBnz   = 4'b1001;
    localparam logic [3:0] OpNop   = 4'b1010;
    localparam logic [3:0] OpBpz   = 4'b1101;

    // ORI and SHIFT ignore opcode bit 3.
    localparam logic [2:0] OpOriLo   = 3'b111;
    localparam logic [2:0] OpShiftLo = 3'b011;

    localparam logic [RegAddrW-1:0] OriDest = 2'b01;

    localparam logic RegInAlu = 1'b0;
    localparam logic RegInMem = 1'b1;

    typedef enum logic [1:0] {
        StIdle,
        StWaitMem,
        StHalted
    } wb_state_e;

    function automatic logic op_is_ori(logic [3:0] op);
        return op[2:0] == OpOriLo;
    endfunction

    function automatic logic op_is_shift(logic [3:0] op);
        return op[2:0] == OpShiftLo;
    endfunction

    function automatic logic op_writes(logic [3:0] op);
        return (op == OpLoad) || (op == OpAdd) || (op == OpSub) || (op == OpNand) ||
               op_is_ori(op) || op_is_shift(op);
    endfunction

    function automatic logic [RegAddrW-1:0] op_dest(logic [3:0] op, logic [RegAddrW-1:0] dst);
        return op_is_ori(op) ? OriDest : dst;
    endfunction

    // One bit per architectural register the instruction reads.
    function automatic logic [NumRegs-1:0] src_mask(logic [IrW-1:0] ir);
        logic [3:0]         op;
        logic [NumRegs-1:0] mask;
        op   = ir[3:0];
        mask = '0;
        if ((op == OpAdd) || (op == OpSub) || (op == OpNand) || (op == OpStore)) begin
            mask[ir[7:6]] = 1'b1;
            mask[ir[5:4]] = 1'b1;
        end else if (op == OpLoad) begin
            mask[ir[5:4]] = 1'b1;
        end else if (op_is_shift(op)) begin
            mask[ir[7:6]] = 1'b1;
        end else if (op_is_ori(op)) begin
            mask[OriDest] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters: issue increments, retire decrements, both saturate
// and raise a sticky error instead of wrapping.
module wb_scoreboard
    import wb_control_pkg::*;
(
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               inc_i,
    input  logic [RegAddrW-1:0]                inc_addr_i,
    input  logic                               dec_i,
    input  logic [RegAddrW-1:0]                dec_addr_i,
    output logic [NumRegs-1:0][1:0]            count_o,
    output logic                               err_o
);

    logic [NumRegs-1:0][1:0] count_q, count_d;
    logic                    err_q, err_d;
    logic [NumRegs-1:0]      up, dn;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        up      = '0;
        dn      = '0;
        for (int r = 0; r < NumRegs; r++) begin
            up[r] = inc_i && (inc_addr_i == RegAddrW'(r));
            dn[r] = dec_i && (dec_addr_i == RegAddrW'(r));
            if (up[r] && !dn[r]) begin
                if (count_q[r] == 2'd3) begin
                    err_d = 1'b1;
                end else begin
                    count_d[r] = count_q[r] + 2'd1;
                end
            end else if (dn[r] && !up[r]) begin
                if (count_q[r] == 2'd0) begin
                    err_d = 1'b1;
                end else begin
                    count_d[r] = count_q[r] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count_o = count_q;
    assign err_o   = err_q;

endmodule

// File: rtl/wb_control.sv
// Write-back stage control: accepts the WB instruction, sequences register-file writes
// (ALU results next cycle, loads after memory data) and raises RF-stage hazard stalls.
module wb_control
    import wb_control_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [IrW-1:0]      IR4,
    input  logic                IR4Valid,
    output logic                IR4Ready,
    input  logic                MemReady,
    input  logic                IssueValid,
    input  logic [IrW-1:0]      IssueIR,
    input  logic [IrW-1:0]      IR2,
    output logic                RFWrite,
    output logic [RegAddrW-1:0] WriteAddr,
    output logic                RegInSel,
    output logic                FlagWrite,
    output logic                Stall,
    output logic                Halt,
    output logic                ScoreErr
);

    wb_state_e             state_q, state_d;
    logic                  rf_write_q, rf_write_d;
    logic                  flag_write_q, flag_write_d;
    logic [RegAddrW-1:0]   write_addr_q, write_addr_d;
    logic                  reg_in_sel_q, reg_in_sel_d;
    logic [RegAddrW-1:0]   ld_dest_q, ld_dest_d;
    logic [3:0]            ir4_op;
    logic [NumRegs-1:0][1:0] count;
    logic [NumRegs-1:0]    busy;
    logic                  unused_src_fields;

    assign ir4_op = IR4[3:0];

    // Source fields only matter for the RF-stage hazard check.
    assign unused_src_fields = ^{IR4[5:4], IssueIR[5:4]};

    always_comb begin
        state_d      = state_q;
        rf_write_d   = 1'b0;
        flag_write_d = 1'b0;
        write_addr_d = write_addr_q;
        reg_in_sel_d = reg_in_sel_q;
        ld_dest_d    = ld_dest_q;
        unique case (state_q)
            StIdle: begin
                if (IR4Valid) begin
                    if (ir4_op == OpLoad) begin
                        state_d   = StWaitMem;
                        ld_dest_d = IR4[7:6];
                    end else if (op_writes(ir4_op)) begin
                        rf_write_d   = 1'b1;
                        flag_write_d = 1'b1;
                        write_addr_d = op_dest(ir4_op, IR4[7:6]);
                        reg_in_sel_d = RegInAlu;
                    end else if (ir4_op == OpStop) begin
                        state_d = StHalted;
                    end
                end
            end
            StWaitMem: begin
                if (MemReady) begin
                    rf_write_d   = 1'b1;
                    write_addr_d = ld_dest_q;
                    reg_in_sel_d = RegInMem;
                    state_d      = StIdle;
                end
            end
            StHalted: begin
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= StIdle;
            rf_write_q   <= 1'b0;
            flag_write_q <= 1'b0;
            write_addr_q <= '0;
            reg_in_sel_q <= RegInAlu;
            ld_dest_q    <= '0;
        end else begin
            state_q      <= state_d;
            rf_write_q   <= rf_write_d;
            flag_write_q <= flag_write_d;
            write_addr_q <= write_addr_d;
            reg_in_sel_q <= reg_in_sel_d;
            ld_dest_q    <= ld_dest_d;
        end
    end

    wb_scoreboard u_scoreboard (
        .clk_i      (clock),
        .rst_ni     (reset),
        .inc_i      (IssueValid && op_writes(IssueIR[3:0])),
        .inc_addr_i (op_dest(IssueIR[3:0], IssueIR[7:6])),
        .dec_i      (rf_write_q),
        .dec_addr_i (write_addr_q),
        .count_o    (count),
        .err_o      (ScoreErr)
    );

    always_comb begin
        busy = '0;
        for (int r = 0; r < NumRegs; r++) begin
            busy[r] = (count[r] != 2'd0);
        end
    end

    // Gated by reset so the block never claims readiness during the reset cycle.
    assign IR4Ready  = reset && (state_q == StIdle);
    assign Halt      = (state_q == StHalted);
    assign Stall     = (state_q != StHalted) && |(src_mask(IR2) & busy);
    assign RFWrite   = rf_write_q;
    assign FlagWrite = flag_write_q;
    assign WriteAddr = write_addr_q;
    assign RegInSel  = reg_in_sel_q;

endmodule

// File: tb/tb_wb_control.sv
// Bench for wb_control: directed scenarios followed by random traffic, all checked
// against a cycle-level behavioural model of the write-back controller.
module tb_wb_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ir4;
    logic       ir4_valid;
    logic       ir4_ready;
    logic       mem_ready;
    logic       issue_valid;
    logic [7:0] issue_ir;
    logic [7:0] ir2;
    logic       rf_write;
    logic [1:0] write_addr;
    logic       reg_in_sel;
    logic       flag_write;
    logic       stall;
    logic       halt;
    logic       score_err;

    int n_pass  = 0;
    int n_total = 0;

    // Model state
    bit known = 0;
    bit m_wait, m_halt, m_err, m_rfw, m_fw, m_sel;
    int m_addr, m_ld;
    int cnt[4];

    always #5 clk = ~clk;

    wb_control dut (
        .clock      (clk),
        .reset      (rst_n),
        .IR4        (ir4),
        .IR4Valid   (ir4_valid),
        .IR4Ready   (ir4_ready),
        .MemReady   (mem_ready),
        .IssueValid (issue_valid),
        .IssueIR    (issue_ir),
        .IR2        (ir2),
        .RFWrite    (rf_write),
        .WriteAddr  (write_addr),
        .RegInSel   (reg_in_sel),
        .FlagWrite  (flag_write),
        .Stall      (stall),
        .Halt       (halt),
        .ScoreErr   (score_err)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic bit m_writes(logic [7:0] ir);
        case (ir[3:0])
            4'h0, 4'h4, 4'h6, 4'h8, 4'h7, 4'hF, 4'h3, 4'hB: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_dest(logic [7:0] ir);
        if (ir[3:0] == 4'h7 || ir[3:0] == 4'hF) return 1;
        return int'(ir[7:6]);
    endfunction

    function automatic bit [3:0] m_reads(logic [7:0] ir);
        bit [3:0] r;
        r = '0;
        case (ir[3:0])
            4'h4, 4'h6, 4'h8, 4'h2: begin r[ir[7:6]] = 1'b1; r[ir[5:4]] = 1'b1; end
            4'h0:                   r[ir[5:4]] = 1'b1;
            4'h3, 4'hB:             r[ir[7:6]] = 1'b1;
            4'h7, 4'hF:             r[1] = 1'b1;
            default:                r = '0;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        int up;
        int dn;
        if (!rst_n) begin
            foreach (cnt[r]) cnt[r] = 0;
            m_err = 0; m_wait = 0; m_halt = 0;
            m_rfw = 0; m_fw = 0; m_sel = 0; m_addr = 0; m_ld = 0;
            known = 1;
            return;
        end
        up = -1;
        dn = -1;
        if (issue_valid && m_writes(issue_ir)) up = m_dest(issue_ir);
        if (m_rfw) dn = m_addr;
        if (up != dn) begin
            if (up >= 0) begin
                if (cnt[up] == 3) m_err = 1; else cnt[up]++;
            end
            if (dn >= 0) begin
                if (cnt[dn] == 0) m_err = 1; else cnt[dn]--;
            end
        end
        m_rfw = 0;
        m_fw  = 0;
        if (m_halt) begin
        end else if (m_wait) begin
            if (mem_ready) begin
                m_rfw = 1; m_sel = 1; m_addr = m_ld; m_wait = 0;
            end
        end else if (ir4_valid) begin
            if (ir4[3:0] == 4'h0) begin
                m_wait = 1; m_ld = int'(ir4[7:6]);
            end else if (m_writes(ir4)) begin
                m_rfw = 1; m_fw = 1; m_sel = 0; m_addr = m_dest(ir4);
            end else if (ir4[3:0] == 4'h1) begin
                m_halt = 1;
            end
        end
    endtask

    task automatic compare_all();
        bit [3:0] busy;
        logic     exp_stall;
        logic     exp_ready;
        if (!known) return;
        foreach (cnt[r]) busy[r] = (cnt[r] > 0);
        exp_stall = !m_halt && ((m_reads(ir2) & busy) != 4'b0);
        exp_ready = rst_n && !m_wait && !m_halt;
        chk("ir4_ready", {7'b0, ir4_ready}, {7'b0, exp_ready});
        chk("rf_write", {7'b0, rf_write}, {7'b0, m_rfw});
        chk("flag_write", {7'b0, flag_write}, {7'b0, m_fw});
        chk("write_addr", {6'b0, write_addr}, 8'(m_addr));
        chk("reg_in_sel", {7'b0, reg_in_sel}, {7'b0, m_sel});
        chk("halt", {7'b0, halt}, {7'b0, m_halt});
        chk("score_err", {7'b0, score_err}, {7'b0, m_err});
        chk("stall", {7'b0, stall}, {7'b0, exp_stall});
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        ir4_valid   = 1'b0;
        issue_valid = 1'b0;
        mem_ready   = 1'b0;
        ir2         = 8'h0A;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        ir4         = 8'h0A;
        ir4_valid   = 1'b0;
        mem_ready   = 1'b0;
        issue_valid = 1'b0;
        issue_ir    = 8'h0A;
        ir2         = 8'h0A;
        #1;
        chk("ready_in_reset", {7'b0, ir4_ready}, 8'h00);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_after_release", {7'b0, ir4_ready}, 8'h01);

        // ADD into R2: one-cycle registered write plus flag write
        ir4 = 8'b10_01_0100; ir4_valid = 1'b1;
        tick();
        chk("add_rfw", {7'b0, rf_write}, 8'h01);
        chk("add_addr", {6'b0, write_addr}, 8'h02);
        chk("add_sel", {7'b0, reg_in_sel}, 8'h00);
        chk("add_fw", {7'b0, flag_write}, 8'h01);
        ir4_valid = 1'b0;
        tick();
        chk("add_rfw_drop", {7'b0, rf_write}, 8'h00);
        chk("add_fw_drop", {7'b0, flag_write}, 8'h00);

        // LOAD into R3 with memory held off for three cycles
        do_reset();
        ir4 = 8'b11_00_0000; ir4_valid = 1'b1; mem_ready = 1'b0;
        tick();
        ir4_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("load_wait_ready", {7'b0, ir4_ready}, 8'h00);
            chk("load_wait_rfw", {7'b0, rf_write}, 8'h00);
            tick();
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("load_rfw", {7'b0, rf_write}, 8'h01);
        chk("load_addr", {6'b0, write_addr}, 8'h03);
        chk("load_sel", {7'b0, reg_in_sel}, 8'h01);
        chk("load_ready_back", {7'b0, ir4_ready}, 8'h01);

        // ORI in flight, ADD in RF reads R1
        do_reset();
        issue_ir = 8'b00_00_0111; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        ir2 = 8'b01_00_0100;
        #1;
        chk("hazard_stall", {7'b0, stall}, 8'h01);
        ir4 = 8'b00_00_0111; ir4_valid = 1'b1;
        tick();
        ir4_valid = 1'b0;
        chk("hazard_stall_during_wb", {7'b0, stall}, 8'h01);
        chk("ori_addr", {6'b0, write_addr}, 8'h01);
        tick();
        chk("hazard_clear", {7'b0, stall}, 8'h00);

        // Saturate R2, then drain it; then issue+retire on R0 together
        do_reset();
        ir2 = 8'b10_00_0011;
        issue_ir = 8'b10_00_0110; issue_valid = 1'b1;
        tick(); tick(); tick();
        chk("sat_no_err_yet", {7'b0, score_err}, 8'h00);
        tick();
        chk("sat_err", {7'b0, score_err}, 8'h01);
        issue_valid = 1'b0;
        ir4 = 8'b10_00_0100; ir4_valid = 1'b1;
        tick(); tick(); tick();
        ir4_valid = 1'b0;
        chk("drain_stall_last", {7'b0, stall}, 8'h01);
        tick();
        chk("drain_stall_clear", {7'b0, stall}, 8'h00);
        issue_ir = 8'b00_00_0100; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        ir4 = 8'b00_00_0100; ir4_valid = 1'b1;
        tick();
        ir4_valid = 1'b0; issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        ir2 = 8'b00_00_0011;
        tick();
        chk("same_reg_inc_dec", {7'b0, stall}, 8'h01);

        // Reset while waiting on memory
        do_reset();
        ir4 = 8'b01_00_0000; ir4_valid = 1'b1;
        tick();
        ir4_valid = 1'b0; mem_ready = 1'b1; rst_n = 1'b0;
        tick();
        chk("rst_wait_ready_low", {7'b0, ir4_ready}, 8'h00);
        rst_n = 1'b1; ir2 = 8'b01_01_0100;
        #1;
        chk("rst_wait_idle", {7'b0, ir4_ready}, 8'h01);
        chk("rst_wait_stall", {7'b0, stall}, 8'h00);
        tick();
        mem_ready = 1'b0;
        chk("rst_wait_no_rfw", {7'b0, rf_write}, 8'h00);

        // STOP, then an ADD must not write; stall suppressed while halted
        do_reset();
        issue_ir = 8'b00_00_0111; issue_valid = 1'b1;
        ir4 = 8'b00_00_0001; ir4_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        chk("stop_halt", {7'b0, halt}, 8'h01);
        chk("stop_ready", {7'b0, ir4_ready}, 8'h00);
        ir4 = 8'b01_01_0100; ir2 = 8'b00_00_0111;
        tick();
        chk("halted_no_rfw", {7'b0, rf_write}, 8'h00);
        chk("halted_no_stall", {7'b0, stall}, 8'h00);
        ir4_valid = 1'b0;

        // Random traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst_n       = ($urandom_range(0, 39) != 0);
            ir4_valid   = ($urandom_range(0, 1) == 1);
            ir4         = 8'($urandom);
            if (ir4[3:0] == 4'h1 && $urandom_range(0, 3) != 0) ir4[3:0] = 4'hA;
            mem_ready   = ($urandom_range(0, 2) == 0);
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_ir    = 8'($urandom);
            ir2         = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
